eth_crc32_byte: RTL and testbench
=================================

// Module: eth_crc32_byte
// PURPOSE
// - Byte-serial IEEE 802.3 CRC-32 generator for the Ethernet TX encapsulation path.
// - Folds one payload byte per eth_tx_clk cycle into a running CRC. The next-state logic is
//   combinational and the state is registered.
// - The encapsulation FSM samples result after the last covered byte and appends it as the FCS.
// PARAMETERS
// - POLY_REFL  32'hEDB88320  reflected form of generator polynomial 0x04C11DB7
// - INIT_VAL   32'hFFFFFFFF  CRC register value after reset
// - XOR_OUT    32'hFFFFFFFF  mask XORed onto the register to form result
// PORTS
// - eth_tx_clk  in   1   TX byte clock; all state changes on its rising edge
// - rst         in   1   reset, synchronous, active-low
// - updatecrc   in   1   1 = fold data into the CRC at this edge; 0 = hold
// - data        in   8   byte to fold in, processed LSB first (wire order)
// - result      out  32  running FCS = crc_reg ^ XOR_OUT
// - crc_good    out  1   only when CRC32_RESIDUE_CHK_EN is defined; see CONFIGURATION
// BEHAVIOUR
// - Reset and clock: reset rst, synchronous, active-low; clock eth_tx_clk.
// - Reset: on a rising edge with rst==0, crc_reg <= INIT_VAL.
//   - result is therefore 32'h00000000 after reset.
//   - Reset has priority over updatecrc and may be applied mid-frame; the partial CRC is discarded.
// - Update: on a rising edge with rst==1 and updatecrc==1, crc_reg <= f(crc_reg, data). f is 8 unrolled steps:
//   - i = 0..7: c = crc ^ {31'b0, data[i]}
//   - crc = c[0] ? (c >> 1) ^ POLY_REFL : (c >> 1)
//   - Implement as a pure function / combinational block; no multicycle or iterative FSM.
// - Hold: with rst==1 and updatecrc==0, crc_reg keeps its value.
//   - data is ignored (X on data is harmless).
// - Latency: result is combinational from crc_reg.
//   - It reflects every byte accepted up to and including the most recent rising edge.
//   - A byte presented with updatecrc=1 appears in result one cycle later.
// - Output byte order: the FCS goes on the wire as result[7:0], [15:8], [23:16], [31:24], each byte LSB first.
// - Widths: all arithmetic is 32-bit and modulo-2; no carries. No internal counters; no wrap-around conditions.
// - Frame length: unbounded; the block accepts any number of bytes between resets.
// - Simultaneous rst==0 and updatecrc==1: reset wins; that byte is not folded in.
// - No outputs other than result (and crc_good if enabled); no handshake back-pressure.
//   The block accepts a byte every cycle.
// CONFIGURATION
// - CRC32_RESIDUE_CHK_EN defined: adds output crc_good, equal to (crc_reg == 32'hDEBB20E3).
//   - This holds after a frame plus its FCS has been folded in, i.e. the good-frame residue.
//   - crc_good is 0 after reset.
//   - Intended for loopback/RX reuse.
// - CRC32_RESIDUE_CHK_EN undefined: crc_good port and comparator are absent. All other behaviour is identical.
// TESTING
// - Release reset, no update: result == 32'h00000000, and stays there for 10 idle cycles.
// - Feed ASCII "123456789" (8'h31..8'h39), updatecrc=1 for 9 cycles:
//   next cycle result == 32'hCBF43926.
// - Feed single byte 8'h00: result == 32'hD202EF8D. Then drop updatecrc with random data for 5 cycles:
//   result unchanged.
// - Feed "12345", pulse rst=0 for one cycle (updatecrc=1 held), then feed "123456789":
//   result == 32'hCBF43926, proving reset priority and clean restart.
// - Toggle updatecrc every other cycle while streaming "123456789" (bytes held when updatecrc=0):
//   result == 32'hCBF43926.
// - With CRC32_RESIDUE_CHK_EN: feed "123456789" then FCS bytes 8'h26, 8'h39, 8'hF4, 8'hCB:
//   crc_good==1 and result == 32'h2144DF1C. Corrupt one payload bit and repeat: crc_good==0.

Source files
------------

// File: rtl/eth_crc32_byte.sv
// ---------------------------------------------------------------------------
// eth_crc32_byte
// ---------------------------------------------------------------------------
// Byte-serial IEEE 802.3 CRC-32 generator for the Ethernet TX encapsulation
// path. One payload byte per eth_tx_clk cycle is folded into a running CRC.
// The next-state logic is purely combinational: eight reflected
// shift/XOR steps are unrolled into a single cycle. The CRC state is held in
// a register.
//
// Ports
//   eth_tx_clk  in   1   TX byte clock; all state changes on its rising edge
//   rst         in   1   synchronous, active-low reset (loads INIT_VAL)
//   updatecrc   in   1   1 = fold data into the CRC at this edge, 0 = hold
//   data        in   8   byte to fold in, LSB first (wire order)
//   result      out  32  running FCS = crc_r ^ XOR_OUT
//   crc_good    out  1   present only with CRC32_RESIDUE_CHK_EN defined
//
// Build option
//   CRC32_RESIDUE_CHK_EN : adds crc_good, which is high when the register
//                          holds the good-frame residue 32'hDEBB20E3. This
//                          residue appears after a frame and its own FCS have
//                          been folded in (loopback / RX reuse).
//
// The FCS is sent as result[7:0], [15:8], [23:16], [31:24], and each byte
// is sent LSB first.
// ---------------------------------------------------------------------------
module eth_crc32_byte #(
    parameter logic [31:0] POLY_REFL = 32'hEDB88320,
    parameter logic [31:0] INIT_VAL  = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT   = 32'hFFFFFFFF
) (
    input  logic        eth_tx_clk,
    input  logic        rst,
    input  logic        updatecrc,
    input  logic [7:0]  data,
    output logic [31:0] result
`ifdef CRC32_RESIDUE_CHK_EN
    ,
    output logic        crc_good
`endif
);

    localparam logic [31:0] GOOD_RESIDUE = 32'hDEBB20E3;

    logic [31:0] crc_r;
    logic [31:0] crc_next_s;

    // Folds one byte into a reflected CRC-32. Bit 0 of the byte goes in
    // first, which matches the order in which it leaves on the wire.
    function automatic logic [31:0] crc32_fold_byte(
        input logic [31:0] crc_in,
        input logic [7:0]  byte_in
    );
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = c ^ {31'b0, byte_in[i]};
            if (c[0]) begin
                c = (c >> 1) ^ POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Next CRC state: fold the byte when updatecrc is high, otherwise hold.
    // While holding, data is not used, so X on data cannot reach the state.
    always_comb begin
        crc_next_s = crc_r;
        if (updatecrc) begin
            crc_next_s = crc32_fold_byte(crc_r, data);
        end else begin
            crc_next_s = crc_r;
        end
    end

    // CRC register. Reset has priority over updatecrc, so any partial CRC
    // from an interrupted frame is discarded.
    always_ff @(posedge eth_tx_clk) begin
        if (!rst) begin
            crc_r <= INIT_VAL;
        end else begin
            crc_r <= crc_next_s;
        end
    end

    // The FCS is taken directly from the register, so it covers every byte
    // accepted up to and including the last edge.
    assign result = crc_r ^ XOR_OUT;

`ifdef CRC32_RESIDUE_CHK_EN
    // Good-frame residue detector. INIT_VAL differs from GOOD_RESIDUE, so
    // crc_good is low after reset.
    assign crc_good = (crc_r == GOOD_RESIDUE);
`endif

endmodule

// File: tb/tb_eth_crc32_byte.sv
// ---------------------------------------------------------------------------
// tb_eth_crc32_byte
// Self-checking bench for eth_crc32_byte. A stimulus table, plus a few
// hand-written sequences, drives the DUT one cycle at a time. On each drive
// the bench's own MSB-first CRC model pushes the expected result onto a
// scoreboard queue. That entry is popped and compared 1 ns after the clock
// edge. Table rows marked for checking are also compared against known
// constants.
// ---------------------------------------------------------------------------
module tb_eth_crc32_byte;

    logic        eth_tx_clk;
    logic        rst;
    logic        updatecrc;
    logic [7:0]  data;
    logic [31:0] result;
`ifdef CRC32_RESIDUE_CHK_EN
    logic        crc_good;
`endif

    eth_crc32_byte dut (
        .eth_tx_clk (eth_tx_clk),
        .rst        (rst),
        .updatecrc  (updatecrc),
        .data       (data),
        .result     (result)
`ifdef CRC32_RESIDUE_CHK_EN
        ,
        .crc_good   (crc_good)
`endif
    );

    initial eth_tx_clk = 1'b0;
    always #5 eth_tx_clk = ~eth_tx_clk;

    typedef struct {
        logic        rst_v;
        logic        upd_v;
        logic [7:0]  data_v;
        logic        chk_v;
        logic [31:0] exp_v;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_q[$];
    logic [31:0] model_crc;
    int          checks;
    int          errors;

    // Reverses the bit order of a 32-bit word.
    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Reference model that works in the non-reflected (MSB-first) domain
    // with the generator polynomial 0x04C11DB7.
    function automatic logic [31:0] model_fold(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = bitrev32(crc);
        for (int i = 0; i < 8; i++) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ 32'h04C11DB7;
        end
        return bitrev32(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic r, input logic u, input logic [7:0] d,
                           input logic c, input logic [31:0] e);
        vec_t v;
        v.rst_v = r; v.upd_v = u; v.data_v = d; v.chk_v = c; v.exp_v = e;
        vecs.push_back(v);
    endtask

    // Appends ASCII "1".."n" as updating bytes. Only the last one is checked.
    task automatic add_digits(input int n, input logic c, input logic [31:0] e);
        for (int i = 1; i <= n; i++) begin
            logic [7:0] b;
            b = 8'h30 + 8'(i);
            add_vec(1'b1, 1'b1, b, (i == n) ? c : 1'b0, e);
        end
    endtask

    // Drives one cycle and pushes the model's prediction onto the queue.
    // The prediction is then popped and compared after the edge.
    task automatic drive(input logic r, input logic u, input logic [7:0] d, input string tag);
        logic [31:0] exp;
        rst = r; updatecrc = u; data = d;
        if (!r)     model_crc = 32'hFFFFFFFF;
        else if (u) model_crc = model_fold(model_crc, d);
        sb_q.push_back(model_crc ^ 32'hFFFFFFFF);
        @(posedge eth_tx_clk);
        #1;
        exp = sb_q.pop_front();
        check({"sb_result_", tag}, result, exp);
`ifdef CRC32_RESIDUE_CHK_EN
        check({"sb_crc_good_", tag}, {31'b0, crc_good}, {31'b0, model_crc == 32'hDEBB20E3});
`endif
    endtask

    // Feeds "123456789" with the first byte optionally corrupted, followed
    // by the FCS of the uncorrupted string.
    task automatic residue_frame(input logic corrupt, input string tag);
        logic [7:0] fcs [4];
        fcs[0] = 8'h26; fcs[1] = 8'h39; fcs[2] = 8'hF4; fcs[3] = 8'hCB;
        drive(1'b0, 1'b0, 8'h00, tag);
        for (int i = 1; i <= 9; i++) begin
            logic [7:0] b;
            b = 8'h30 + 8'(i);
            if (corrupt && i == 1) b = b ^ 8'h01;
            drive(1'b1, 1'b1, b, tag);
        end
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, fcs[i], tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0; updatecrc = 1'b0; data = 8'h00;
        model_crc = 32'hFFFFFFFF;

        // Reset, then 10 idle cycles with random data.
        add_vec(1'b0, 1'b0, 8'h00, 1'b1, 32'h00000000);
        add_vec(1'b0, 1'b1, 8'hA5, 1'b1, 32'h00000000);
        for (int i = 0; i < 10; i++)
            add_vec(1'b1, 1'b0, 8'($urandom), 1'b1, 32'h00000000);
        // Check value for "123456789".
        add_digits(9, 1'b1, 32'hCBF43926);
        // Single zero byte, then holds with random data.
        add_vec(1'b0, 1'b0, 8'h00, 1'b1, 32'h00000000);
        add_vec(1'b1, 1'b1, 8'h00, 1'b1, 32'hD202EF8D);
        for (int i = 0; i < 5; i++)
            add_vec(1'b1, 1'b0, 8'($urandom), 1'b1, 32'hD202EF8D);
        // Mid-frame reset wins over updatecrc, then a clean restart.
        add_vec(1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        add_digits(5, 1'b0, 32'h0);
        add_vec(1'b0, 1'b1, 8'h36, 1'b1, 32'h00000000);
        add_digits(9, 1'b1, 32'hCBF43926);
        // updatecrc toggled, with each byte held across its idle cycle.
        add_vec(1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        for (int i = 1; i <= 9; i++) begin
            logic [7:0] b;
            b = 8'h30 + 8'(i);
            add_vec(1'b1, 1'b0, b, 1'b0, 32'h0);
            add_vec(1'b1, 1'b1, b, (i == 9), 32'hCBF43926);
        end

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst_v, vecs[k].upd_v, vecs[k].data_v, $sformatf("v%0d", k));
            if (vecs[k].chk_v)
                check($sformatf("const_v%0d", k), result, vecs[k].exp_v);
        end

        // Long random stream compared only against the model.
        drive(1'b0, 1'b0, 8'h00, "rnd_rst");
        for (int i = 0; i < 200; i++)
            drive(1'b1, 1'($urandom_range(0, 3) != 0), 8'($urandom), "rnd");

`ifdef CRC32_RESIDUE_CHK_EN
        residue_frame(1'b0, "res_good");
        check("residue_good", {31'b0, crc_good}, 32'd1);
        check("residue_result", result, 32'h2144DF1C);
        residue_frame(1'b1, "res_bad");
        check("residue_bad", {31'b0, crc_good}, 32'd0);
        drive(1'b0, 1'b0, 8'h00, "res_rst");
        check("crc_good_reset", {31'b0, crc_good}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
